// File: rtl/bpsk_packet_deframer.sv
// bpsk_packet_deframer: hunts for the preamble in the demodulated bit stream, then rebuilds an indexed packet.
module bpsk_packet_deframer #(
  parameter int PACKET_WIDTH = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int PREAMBLE_LENGTH = 16,
  parameter logic [PREAMBLE_LENGTH-1:0] PREAMBLE = 16'hA5F0,
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_valid,
  output logic [PACKET_WIDTH*8-1:0] sys_packet,
  output logic packet_valid,
  output logic index_error,
  output logic frame_abort,
  output logic busy
);
  localparam int EW = INDEX_WIDTH + 8;
  localparam int BW = $clog2(EW);
  localparam int CW = $clog2(PACKET_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {HUNT, PAYLOAD} state_t;
  state_t state;
  logic [PREAMBLE_LENGTH-1:0] sr, sr_n;
  logic [EW-1:0] entry, entry_n;
  logic [PACKET_WIDTH*8-1:0] assembly, assembly_n;
  logic [PACKET_WIDTH-1:0] seen, seen_n;
  logic err, err_n;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] ent_cnt;
  logic [TW-1:0] idle;
  logic [INDEX_WIDTH-1:0] idx;
  logic in_range;
  assign busy = (state == PAYLOAD);
  // Decode of the entry as it would look with the current bit shifted in
  always_comb begin
    sr_n = {sr[PREAMBLE_LENGTH-2:0], bit_in};
    entry_n = {entry[EW-2:0], bit_in};
    idx = entry_n[EW-1:8];
    in_range = {1'b0, idx} < (INDEX_WIDTH+1)'(PACKET_WIDTH);
    assembly_n = assembly;
    seen_n = seen;
    err_n = err | ~in_range;
    if (in_range) begin
      assembly_n[idx*8 +: 8] = entry_n[7:0];
      seen_n[idx] = 1'b1;
      err_n = err | seen[idx];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
      sr <= '0;
      entry <= '0;
      assembly <= '0;
      seen <= '0;
      err <= 1'b0;
      bit_cnt <= '0;
      ent_cnt <= '0;
      idle <= '0;
      sys_packet <= '0;
      packet_valid <= 1'b0;
      index_error <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      frame_abort <= 1'b0;
      if (state == HUNT) begin
        if (bit_valid && sr_n == PREAMBLE) begin
          state <= PAYLOAD;
          sr <= '0;
          entry <= '0;
          assembly <= '0;
          seen <= '0;
          err <= 1'b0;
          bit_cnt <= '0;
          ent_cnt <= '0;
          idle <= '0;
        end else if (bit_valid) begin
          sr <= sr_n;
        end
      end else if (idle == TW'(TIMEOUT)) begin
        state <= HUNT;
        frame_abort <= 1'b1;
      end else if (bit_valid) begin
        idle <= '0;
        entry <= entry_n;
        bit_cnt <= (bit_cnt == BW'(EW-1)) ? '0 : bit_cnt + 1'b1;
        if (bit_cnt == BW'(EW-1)) begin
          ent_cnt <= ent_cnt + 1'b1;
          assembly <= assembly_n;
          seen <= seen_n;
          err <= err_n;
          if (ent_cnt == CW'(PACKET_WIDTH-1)) begin
            sys_packet <= assembly_n;
            packet_valid <= 1'b1;
            index_error <= err_n | ~&seen_n;
            state <= HUNT;
          end
        end
      end else begin
        idle <= idle + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bpsk_packet_deframer.sv
// tb_bpsk_packet_deframer: frame-level reference model plus directed and random frames.
module tb_bpsk_packet_deframer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic [31:0] sys_packet;
  logic packet_valid, index_error, frame_abort, busy;
  int checks = 0;
  int passes = 0;
  int pv_cnt = 0;
  int ab_cnt = 0;
  logic [31:0] last_pkt = '0;
  logic [31:0] prev_pkt = '0;
  logic last_err = 1'b0;
  bit started = 1'b0;
  bit m_in_frame, m_pv, m_err, m_abort;
  int m_hist, m_idle;
  bit m_bits[$];
  logic [31:0] m_pkt;

  bpsk_packet_deframer #(.PACKET_WIDTH(4), .INDEX_WIDTH(2), .PREAMBLE_LENGTH(8),
                         .PREAMBLE(8'hD5), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .sys_packet(sys_packet), .packet_valid(packet_valid), .index_error(index_error),
    .frame_abort(frame_abort), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
  endtask

  // Reference: bits of a frame are queued, and the packet is rebuilt from the whole list at the end
  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      m_in_frame = 0; m_pv = 0; m_err = 0; m_abort = 0; m_hist = 0; m_idle = 0; m_pkt = '0;
      m_bits.delete();
    end else begin
      m_pv = 0;
      m_abort = 0;
      if (!m_in_frame) begin
        if (bit_valid) begin
          m_hist = ((m_hist << 1) | int'(bit_in)) & 'hFF;
          if (m_hist == 'hD5) begin
            m_in_frame = 1; m_hist = 0; m_idle = 0;
            m_bits.delete();
          end
        end
      end else if (m_idle == 64) begin
        m_abort = 1;
        m_in_frame = 0;
      end else if (bit_valid) begin
        m_idle = 0;
        m_bits.push_back(bit_in);
        if (m_bits.size() == 40) begin
          logic [31:0] a;
          bit [3:0] seen;
          bit err;
          a = '0; seen = '0; err = 0;
          for (int e = 0; e < 4; e++) begin
            int idx, d;
            idx = int'(m_bits[e*10]) * 2 + int'(m_bits[e*10+1]);
            d = 0;
            for (int k = 0; k < 8; k++) d = d * 2 + int'(m_bits[e*10+2+k]);
            if (idx >= 4) err = 1;
            else begin
              if (seen[idx]) err = 1;
              a[idx*8 +: 8] = d[7:0];
              seen[idx] = 1;
            end
          end
          m_pkt = a;
          m_err = err || (seen != 4'hF);
          m_pv = 1;
          m_in_frame = 0;
        end
      end else begin
        m_idle++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("packet_valid", packet_valid, m_pv);
      chk("frame_abort", frame_abort, m_abort);
      chk("busy", busy, m_in_frame);
      chk("sys_packet", sys_packet, m_pkt);
      chk("index_error", index_error, m_err);
      if (packet_valid) begin
        pv_cnt++; prev_pkt = last_pkt; last_pkt = sys_packet; last_err = index_error;
      end
      if (frame_abort) ab_cnt++;
    end
  end

  task automatic send_bit(input logic b, input int gap);
    bit_in = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic send_val(input logic [31:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic send_entry(input int idx, input int dat, input int gap);
    send_val(idx, 2, gap);
    send_val(dat, 8, gap);
  endtask

  task automatic frame(input int i0, input int d0, input int i1, input int d1,
                       input int i2, input int d2, input int i3, input int d3);
    send_val(32'hD5, 8, 4);
    send_entry(i0, d0, 4); send_entry(i1, d1, 4); send_entry(i2, d2, 4); send_entry(i3, d3, 4);
  endtask

  initial begin
    int p, a;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_pkt", sys_packet, 32'h0);
    chk("reset_busy", busy, 1'b0);
    // 1: out-of-order indices
    p = pv_cnt;
    frame(2, 'h33, 0, 'h11, 3, 'h44, 1, 'h22);
    chk("t1_count", pv_cnt - p, 1);
    chk("t1_pkt", last_pkt, 32'h44332211);
    chk("t1_err", last_err, 1'b0);
    // 2: preamble ending inside overlapping noise
    p = pv_cnt;
    send_val(32'hDD, 8, 4);
    send_val(32'h5, 4, 4);
    send_entry(0, 'hA0, 4); send_entry(1, 'hB1, 4); send_entry(2, 'hC2, 4); send_entry(3, 'hD3, 4);
    chk("t2_count", pv_cnt - p, 1);
    chk("t2_pkt", last_pkt, 32'hD3C2B1A0);
    chk("t2_err", last_err, 1'b0);
    // 3: duplicate index, missing slot
    frame(0, 'hAA, 0, 'hBB, 2, 'hCC, 3, 'hDD);
    chk("t3_pkt", last_pkt, 32'hDDCC00BB);
    chk("t3_err", last_err, 1'b1);
    // 4: timeout mid-frame
    p = pv_cnt; a = ab_cnt;
    send_val(32'hD5, 8, 4);
    send_entry(0, 'h01, 4); send_entry(1, 'h02, 4);
    repeat (80) begin @(posedge clk); #1; end
    chk("t4_abort", ab_cnt - a, 1);
    chk("t4_no_pv", pv_cnt - p, 0);
    chk("t4_hold", sys_packet, 32'hDDCC00BB);
    frame(0, 'h01, 1, 'h02, 2, 'h03, 3, 'h04);
    chk("t4_next", last_pkt, 32'h04030201);
    // 5: reset mid-payload
    p = pv_cnt; a = ab_cnt;
    send_val(32'hD5, 8, 4);
    send_entry(0, 'h11, 4);
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    send_entry(1, 'h22, 4); send_entry(2, 'h33, 4); send_entry(3, 'h44, 4);
    chk("t5_no_pv", pv_cnt - p, 0);
    chk("t5_no_abort", ab_cnt - a, 0);
    chk("t5_pkt", sys_packet, 32'h0);
    chk("t5_err", index_error, 1'b0);
    chk("t5_busy", busy, 1'b0);
    frame(3, 'h9C, 2, 'h8B, 1, 'h7A, 0, 'h69);
    chk("t5_next", last_pkt, 32'h9C8B7A69);
    // 6: back-to-back frames
    p = pv_cnt;
    frame(0, 'h10, 1, 'h20, 2, 'h30, 3, 'h40);
    frame(3, 'hF3, 1, 'hF1, 0, 'hF0, 2, 'hF2);
    chk("t6_count", pv_cnt - p, 2);
    chk("t6_first", prev_pkt, 32'h40302010);
    chk("t6_second", last_pkt, 32'hF3F2F1F0);
    // random frames with noise, random gaps and occasional timeouts
    for (int f = 0; f < 30; f++) begin
      int n;
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) send_bit($urandom_range(0, 1), $urandom_range(1, 6));
      send_val(32'hD5, 8, $urandom_range(1, 6));
      for (int e = 0; e < 4; e++) begin
        send_val($urandom_range(0, 3), 2, $urandom_range(1, 6));
        send_val($urandom, 8, $urandom_range(1, 6));
        if ($urandom_range(0, 15) == 0) repeat (70) begin @(posedge clk); #1; end
      end
    end
    repeat (5) begin @(posedge clk); #1; end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/bpsk_packet_deframer.md
Name: bpsk_packet_deframer

Overview:
Receive-side counterpart of the transmit packet path. It takes the demodulated BPSK bit stream and hunts for the preamble. After a match it collects PACKET_WIDTH indexed entries and writes each data byte into the packet slot named by its index. It then presents the rebuilt PACKET_WIDTH*8-bit packet with a one-cycle valid strobe to the downstream byte/UART return path.

Parameters:
PACKET_WIDTH, 8, data bytes per frame.
INDEX_WIDTH, 3, index bits per entry; 2**INDEX_WIDTH >= PACKET_WIDTH required.
PREAMBLE_LENGTH, 16, preamble length in bits.
PREAMBLE, 16'hA5F0, preamble pattern, MSB sent first; must not be all-zero.
TIMEOUT, 4096, max clk cycles allowed between bit_valid strobes inside a frame.

Ports:
clk  in  1  system clock (clk_out_base domain).
reset  in  1  synchronous, active-high reset.
bit_in  in  1  demodulated bit, sampled only when bit_valid=1.
bit_valid  in  1  one-cycle strobe per received symbol.
sys_packet  out  PACKET_WIDTH*8  reassembled packet; byte k occupies [8k+7:8k].
packet_valid  out  1  one-cycle pulse when sys_packet is updated.
index_error  out  1  qualifies packet_valid: a duplicate, out-of-range or missing index occurred in this frame.
frame_abort  out  1  one-cycle pulse when a frame is abandoned on timeout.
busy  out  1  high while in PAYLOAD.

Behaviour:
- Reset, all registers: sys_packet=0, packet_valid=0, index_error=0, frame_abort=0, busy=0, state=HUNT, preamble shift register=0, assembly register=0, seen mask=0, all counters=0.
- Bit order on the wire: preamble MSB first. Then PACKET_WIDTH entries, each made of INDEX_WIDTH index bits (MSB first) followed by 8 data bits (MSB first).
- HUNT state:
  - Each bit_valid shifts bit_in into the LSB of a PREAMBLE_LENGTH shift register.
  - Match test uses the post-shift value {sr[L-2:0],bit_in} == PREAMBLE.
  - On a match, the next cycle is PAYLOAD. Also on the match: clear the shift register, assembly register, seen mask, error flag, bit counter and entry counter.
  - Overlapping patterns are detected; there is no alignment assumption.
- PAYLOAD state:
  - Each bit_valid shifts into a (INDEX_WIDTH+8)-bit entry register; the bit counter increments.
  - When the last bit of an entry is accepted, the index is decoded from the top INDEX_WIDTH bits.
    - If index < PACKET_WIDTH: write the byte into that assembly slot and set the seen bit.
    - If the seen bit was already set: overwrite the slot (last write wins) and set the error flag.
    - If index >= PACKET_WIDTH: discard the byte and set the error flag.
  - The entry counter increments. When it reaches PACKET_WIDTH (on the final bit), the next cycle:
    - sys_packet is loaded with the assembly value, with the final byte included;
    - packet_valid=1 for exactly one cycle;
    - index_error = flag OR (seen mask != all-ones);
    - state returns to HUNT.
  - Latency: packet_valid is asserted exactly 1 cycle after the clk edge that accepts the final bit.
- sys_packet and index_error hold their values until the next packet_valid. index_error is meaningful only with packet_valid or afterwards.
- Timeout:
  - In PAYLOAD, an idle counter resets on each bit_valid and increments otherwise.
  - When it reaches TIMEOUT: frame_abort pulses for 1 cycle, state goes to HUNT, and sys_packet is left unchanged.
  - The idle counter is not active in HUNT.
- Simultaneous events:
  - A bit_valid in the same cycle packet_valid is asserted is processed in HUNT.
  - A bit_valid in the cycle a timeout fires is dropped.
- Reset mid-frame: the frame is discarded with no packet_valid and no frame_abort. The next frame needs a full preamble.
- busy = (state==PAYLOAD).

Test Plan:
Use PACKET_WIDTH=4, INDEX_WIDTH=2, PREAMBLE_LENGTH=8, PREAMBLE=8'hD5, TIMEOUT=64; bit_valid every 4th cycle.
1. Send D5, then entries (2,33),(0,11),(3,44),(1,22) -> one packet_valid 1 cycle after the last bit; sys_packet=32'h44332211; index_error=0; busy falls in the same cycle.
2. Send noise bits 1101_1101 followed by 0101 (D5 ends in the overlap), then entries (0,A0),(1,B1),(2,C2),(3,D3) -> preamble detected; sys_packet=32'hD3C2B1A0.
3. Send D5, then entries (0,AA),(0,BB),(2,CC),(3,DD) -> sys_packet=32'hDDCC00BB; index_error=1.
4. Send D5 and two entries, then hold bit_valid low for 64 cycles -> frame_abort pulses once; sys_packet keeps its prior value; no packet_valid; a following full frame decodes correctly.
5. Assert reset for 1 cycle mid-payload, then send the remaining bits without a preamble -> no packet_valid; all outputs at their reset values; a full frame afterwards succeeds.
6. Send two back-to-back frames with no gap bits -> two packet_valid pulses, each carrying the correct packet.
